// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer.
// The fetch stage looks up pc_if combinationally and receives a hit flag, a
// taken prediction from a 2-bit saturating counter, and the next fetch address.
// The EX stage trains one entry per cycle with the resolved branch outcome.
// A lookup in the same cycle as an update sees the pre-update contents.
module branch_target_buffer #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_if,
    output logic        hit,
    output logic        predict_taken,
    output logic [63:0] predicted_target,
    input  logic        update_valid,
    input  logic [63:0] pc_ex,
    input  logic [63:0] target_ex,
    input  logic        taken_ex
);

    localparam int TAG_W = 64 - IDX_W - 2;

    // Per-entry storage. Only valid and counter are reset; tag and target are
    // don't-care while the entry is invalid.
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [63:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] idx_if;
    logic [TAG_W-1:0] tag_if;
    logic [IDX_W-1:0] idx_ex;
    logic [TAG_W-1:0] tag_ex;
    logic             ex_hit;

    // The two byte-offset bits of each PC play no part in indexing or tagging.
    logic unused_pc_low;
    assign unused_pc_low = ^{pc_if[1:0], pc_ex[1:0]};

    assign idx_if = pc_if[IDX_W+1:2];
    assign tag_if = pc_if[63:IDX_W+2];
    assign idx_ex = pc_ex[IDX_W+1:2];
    assign tag_ex = pc_ex[63:IDX_W+2];

    // Fetch-side lookup: purely combinational against the registered arrays.
    always_comb begin
        hit              = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
        predict_taken    = hit && ctr_q[idx_if][1];
        predicted_target = predict_taken ? target_q[idx_if] : (pc_if + 64'd4);
    end

    // EX-side match used to decide between training and allocating.
    always_comb begin
        ex_hit = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
    end

    // Valid bits and counters: reset wins over any update in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'd1;
            end
        end else if (update_valid) begin
            if (ex_hit) begin
                if (taken_ex) begin
                    if (ctr_q[idx_ex] != 2'd3) ctr_q[idx_ex] <= ctr_q[idx_ex] + 2'd1;
                end else begin
                    if (ctr_q[idx_ex] != 2'd0) ctr_q[idx_ex] <= ctr_q[idx_ex] - 2'd1;
                end
            end else if (taken_ex) begin
                valid_q[idx_ex] <= 1'b1;
                ctr_q[idx_ex]   <= 2'd2;
            end
        end
    end

    // Tag and target: written on every taken update (refresh on hit, fill on miss).
    always_ff @(posedge clk) begin
        if (!reset && update_valid && taken_ex) begin
            tag_q[idx_ex]    <= tag_ex;
            target_q[idx_ex] <= target_ex;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios with
// hand-computed expectations, then randomized traffic compared every cycle
// against a table-based reference of the predictor.
module tb_branch_target_buffer;

    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;

    logic        clk;
    logic        reset;
    logic [63:0] pc_if;
    logic        hit;
    logic        predict_taken;
    logic [63:0] predicted_target;
    logic        update_valid;
    logic [63:0] pc_ex;
    logic [63:0] target_ex;
    logic        taken_ex;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    branch_target_buffer #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_if            (pc_if),
        .hit              (hit),
        .predict_taken    (predict_taken),
        .predicted_target (predicted_target),
        .update_valid     (update_valid),
        .pc_ex            (pc_ex),
        .target_ex        (target_ex),
        .taken_ex         (taken_ex)
    );

    // Clock and initial input values
    initial begin
        clk          = 0;
        reset        = 1;
        pc_if        = 64'h0;
        update_valid = 0;
        pc_ex        = 64'h0;
        target_ex    = 64'h0;
        taken_ex     = 0;
        forever #5 clk = ~clk;
    end

    // Reference: one record per line, keyed by word-address modulo ENTRIES.
    bit          m_valid [ENTRIES];
    logic [63:0] m_word  [ENTRIES];   // full word address (pc >> 2) of the owner
    logic [63:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];

    function automatic int line_of(input logic [63:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [63:0] pc);
        int l = line_of(pc);
        return m_valid[l] && (m_word[l] == (pc >> 2));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t pc_if=%h)", name, act, exp, $time, pc_if);
        end
    endtask

    // Compare process: check outputs against the reference, then advance the
    // reference by the edge that follows (inputs are stable until then).
    always @(negedge clk) begin
        bit          e_hit;
        bit          e_pt;
        logic [63:0] e_tgt;
        int          l;
        if (chk_en) begin
            l     = line_of(pc_if);
            e_hit = m_hit(pc_if);
            e_pt  = e_hit && (m_ctr[l] >= 2);
            e_tgt = e_pt ? m_tgt[l] : pc_if + 64'd4;
            chk("model_hit", {63'b0, hit}, {63'b0, e_hit});
            chk("model_predict_taken", {63'b0, predict_taken}, {63'b0, e_pt});
            chk("model_predicted_target", predicted_target, e_tgt);
        end
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
        end else if (update_valid) begin
            l = line_of(pc_ex);
            if (m_hit(pc_ex)) begin
                if (taken_ex) begin
                    m_ctr[l] = (m_ctr[l] == 3) ? 3 : m_ctr[l] + 1;
                    m_tgt[l] = target_ex;
                end else begin
                    m_ctr[l] = (m_ctr[l] == 0) ? 0 : m_ctr[l] - 1;
                end
            end else if (taken_ex) begin
                m_valid[l] = 1;
                m_word[l]  = pc_ex >> 2;
                m_tgt[l]   = target_ex;
                m_ctr[l]   = 2;
            end
        end
    end

    // Driver: drive one cycle's inputs just after the rising edge, return at
    // the falling edge so the caller can check that cycle's outputs.
    task automatic apply(input logic rst, input logic [63:0] pif, input logic upd,
                         input logic [63:0] pex, input logic [63:0] tex, input logic tk);
        @(posedge clk);
        #1;
        reset        = rst;
        pc_if        = pif;
        update_valid = upd;
        pc_ex        = pex;
        target_ex    = tex;
        taken_ex     = tk;
        @(negedge clk);
        #1;
    endtask

    task automatic look(input logic [63:0] pif);
        apply(0, pif, 0, 64'h0, 64'h0, 0);
    endtask

    task automatic train(input logic [63:0] pif, input logic [63:0] pex,
                         input logic [63:0] tex, input logic tk);
        apply(0, pif, 1, pex, tex, tk);
    endtask

    task automatic lit(input string name, input logic e_hit, input logic e_pt, input logic [63:0] e_tgt);
        chk({name, "_hit"}, {63'b0, hit}, {63'b0, e_hit});
        chk({name, "_pt"}, {63'b0, predict_taken}, {63'b0, e_pt});
        chk({name, "_tgt"}, predicted_target, e_tgt);
    endtask

    logic [55:0] tag_pool [4];

    initial begin
        apply(1, 64'h0, 0, 64'h0, 64'h0, 0);
        apply(1, 64'h0, 0, 64'h0, 64'h0, 0);
        chk_en = 1;

        // After reset: miss, fall through
        look(64'h1000);
        lit("reset_lookup", 0, 0, 64'h1004);

        // Allocate 0x1000 -> 0x2000; invisible in the update cycle itself
        train(64'h1000, 64'h1000, 64'h2000, 1);
        lit("alloc_same_cycle", 0, 0, 64'h1004);
        look(64'h1000);
        lit("alloc_next", 1, 1, 64'h2000);

        // Two not-taken: 2 -> 1 -> 0
        train(64'h1000, 64'h1000, 64'h0, 0);
        lit("nt1_cycle", 1, 1, 64'h2000);
        train(64'h1000, 64'h1000, 64'h0, 0);
        lit("nt2_cycle", 1, 0, 64'h1004);
        look(64'h1000);
        lit("ctr_zero", 1, 0, 64'h1004);

        // Four taken: 0 -> 1 -> 2 -> 3 -> 3 (saturate), then 3 -> 2 stays taken
        train(64'h1000, 64'h1000, 64'h2000, 1);
        train(64'h1000, 64'h1000, 64'h2000, 1);
        train(64'h1000, 64'h1000, 64'h2000, 1);
        train(64'h1000, 64'h1000, 64'h2000, 1);
        look(64'h1000);
        lit("ctr_sat", 1, 1, 64'h2000);
        train(64'h1000, 64'h1000, 64'h0, 0);
        look(64'h1000);
        lit("sat_minus1", 1, 1, 64'h2000);
        train(64'h1000, 64'h1000, 64'h0, 0);
        look(64'h1000);
        lit("sat_minus2", 1, 0, 64'h1004);

        // Aliasing on line 0: 0x1100 replaces 0x1000
        train(64'h0, 64'h1100, 64'h5000, 1);
        look(64'h1000);
        lit("alias_old_miss", 0, 0, 64'h1004);
        look(64'h1100);
        lit("alias_new_hit", 1, 1, 64'h5000);
        train(64'h0, 64'h1200, 64'h6000, 0);
        look(64'h1100);
        lit("alias_nt_keep", 1, 1, 64'h5000);
        look(64'h1200);
        lit("alias_nt_miss", 0, 0, 64'h1204);

        // Same-cycle conflict, low-bit insensitivity, wrap of pc+4
        train(64'h3000, 64'h3000, 64'h4000, 1);
        lit("conflict_same", 0, 0, 64'h3004);
        look(64'h3000);
        lit("conflict_next", 1, 1, 64'h4000);
        look(64'h3003);
        lit("low_bits_ignored", 1, 1, 64'h4000);
        look(64'hFFFF_FFFF_FFFF_FFFC);
        lit("wrap", 0, 0, 64'h0);

        // Reset with a simultaneous allocating update
        apply(1, 64'h3000, 1, 64'h7000, 64'h8000, 1);
        look(64'h7000);
        lit("rst_upd_miss", 0, 0, 64'h7004);
        look(64'h3000);
        lit("rst_old_miss", 0, 0, 64'h3004);

        // Randomized traffic over a few tags and lines to force hits and aliases
        for (int i = 0; i < 4; i++) tag_pool[i] = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
        for (int n = 0; n < 3000; n++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = {tag_pool[$urandom_range(0, 3)], 3'b000, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            b = {tag_pool[$urandom_range(0, 3)], 3'b000, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 15) == 0) a = 64'hFFFF_FFFF_FFFF_FFFC;
            apply(($urandom_range(0, 299) == 0), a, ($urandom_range(0, 3) != 0), b,
                  {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
